// File: rtl/score_digit_addr_pkg.sv
// Shared definitions for the score digit glyph address generator:
// glyph indices, scan FSM states and the glyph base address helper.
package score_pkg;

  localparam int unsigned GLYPH_BLANK = 10;
  localparam int unsigned NUM_GLYPHS  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  // Glyph words are a power of two, so the multiply reduces to a shift.
  function automatic logic [31:0] glyph_base(input logic [3:0]   idx,
                                             input logic [31:0]  base,
                                             input int unsigned  shift);
    return base + (32'(idx) << shift);
  endfunction

endpackage

// File: rtl/score_digit_addr_if.sv
// Scan request / glyph address stream between the score block and the renderer.
interface score_digit_addr_if #(
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 2
);
  logic              scan_req;
  logic              addr_ready;
  logic [ADDR_W-1:0] digit_addr;
  logic [IDX_W-1:0]  digit_idx;
  logic              addr_valid;
  logic              scan_done;
  logic              busy;

  modport master (
    input  scan_req, addr_ready,
    output digit_addr, digit_idx, addr_valid, scan_done, busy
  );

  modport slave (
    output scan_req, addr_ready,
    input  digit_addr, digit_idx, addr_valid, scan_done, busy
  );
endinterface

// File: rtl/score_digit_addr_bcd_digit.sv
// One BCD digit of the score counter; carry_out ripples into the next digit.
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc_in && (digit == 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       digit <= 4'd0;
    else if (clr)    digit <= 4'd0;
    else if (inc_in) digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  end

endmodule

// File: rtl/score_digit_addr.sv
// BCD score counter plus a scan engine that streams one glyph ROM base
// address per digit, MSD first, with optional leading-zero blanking.
module score_digit_addr
  import score_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int GLYPH_WORDS = 64,
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 0,
  parameter int BLANK_LZ    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    score_inc,
  input  logic                    score_clr,
  input  logic                    freeze,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  score_digit_addr_if.master      bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SHIFT = $clog2(GLYPH_WORDS);
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(NUM_DIGITS - 1);

  // Score counter: ripple carry chain of BCD digits, digit 0 least significant.
  logic [NUM_DIGITS:0] carry;
  assign carry[0] = score_inc && !freeze;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (score_clr),
      .inc_in    (carry[i]),
      .digit     (score_bcd[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  overflow <= 1'b0;
    else if (score_clr)         overflow <= 1'b0;
    else if (carry[NUM_DIGITS]) overflow <= 1'b1;
  end

  // Scan engine.
  scan_state_t                state, state_nxt;
  logic [IDX_W-1:0]           pos;
  logic                       lz_active;
  logic [4*NUM_DIGITS-1:0]    shadow;
  logic [3:0]                 cur_digit;
  logic [3:0]                 glyph;
  logic                       accept;

  assign cur_digit = shadow[4*pos +: 4];
  assign accept    = (state == EMIT) && bus.addr_ready;
  assign glyph     = (lz_active && (cur_digit == 4'd0) && (pos != '0))
                     ? 4'(GLYPH_BLANK) : cur_digit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pos       <= '0;
      lz_active <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        pos       <= LAST_POS;
        lz_active <= (BLANK_LZ != 0);
      end else if (accept) begin
        pos <= pos - IDX_W'(1);
        if (cur_digit != 4'd0) lz_active <= 1'b0;
      end
    end
  end

  // The snapshot is pure data and only meaningful once LOAD has run.
  always_ff @(posedge clk) begin
    if (state == LOAD) shadow <= score_bcd;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.scan_req) state_nxt = LOAD;
      LOAD: state_nxt = EMIT;
      EMIT: if (accept && (pos == '0)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.addr_valid = (state == EMIT);
    bus.scan_done  = (state == DONE);
    bus.busy       = (state != IDLE);
    bus.digit_idx  = '0;
    bus.digit_addr = '0;
    if (state == EMIT) begin
      bus.digit_idx  = LAST_POS - pos;
      bus.digit_addr = ADDR_W'(glyph_base(glyph, 32'(BASE_ADDR), SHIFT));
    end
  end

endmodule
